ticket_change_dispenser: RTL and testbench

//  Output-side partner of the ticket-sale controller.

---
 rtl/ticket_change_dispenser.sv | 185 ++++++++++++++++++
 tb/tb_ticket_change_dispenser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ticket_change_dispenser.sv
// ticket_change_dispenser: issues tickets over a req/ack handshake with the
// printer, then pays change as greedy single-cycle coin strobes.
// Every output is a flop. Each *_d value is derived from the next state, so
// a strobe becomes visible in the cycle right after the edge that decided it.
module ticket_change_dispenser #(
    parameter int COIN_BIG    = 10,
    parameter int COIN_MID    = 5,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] ticket_type,
    input  logic [1:0] ticket_count,
    input  logic [7:0] change,
    input  logic       fault_clr,
    output logic       tkt_req,
    output logic [1:0] tkt_type,
    input  logic       tkt_ack,
    output logic       coin_big,
    output logic       coin_mid,
    output logic       coin_one,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [1:0] tickets_out,
    output logic [7:0] change_left
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [7:0] BIG_V = 8'(COIN_BIG);
    localparam logic [7:0] MID_V = 8'(COIN_MID);

    typedef enum logic [2:0] {
        S_IDLE, S_TKT_REQ, S_TKT_GAP, S_COIN, S_DONE, S_FAULT
    } state_t;

    state_t          state_q, state_d;
    logic            start_q, start_d;
    logic [1:0]      type_q, type_d;
    logic [1:0]      rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tkt_req_q, tkt_req_d;
    logic            coin_big_q, coin_big_d;
    logic            coin_mid_q, coin_mid_d;
    logic            coin_one_q, coin_one_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;
    logic [1:0]      tickets_q, tickets_d;
    logic [7:0]      change_q, change_d;
    logic            pay;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        start_d    = start;
        type_d     = type_q;
        rem_d      = rem_q;
        cnt_d      = '0;
        tkt_req_d  = 1'b0;
        coin_big_d = 1'b0;
        coin_mid_d = 1'b0;
        coin_one_d = 1'b0;
        tickets_d  = tickets_q;
        change_d   = change_q;
        pay        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !start_q) begin
                    type_d    = ticket_type;
                    rem_d     = ticket_count;
                    tickets_d = 2'd0;
                    change_d  = change;
                    if (ticket_count != 2'd0) begin
                        state_d   = S_TKT_REQ;
                        tkt_req_d = 1'b1;
                    end else if (change != 8'd0) begin
                        pay = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_TKT_REQ: begin
                if (tkt_ack) begin
                    tickets_d = tickets_q + 2'd1;
                    rem_d     = rem_q - 2'd1;
                    if (rem_q > 2'd1)
                        state_d = S_TKT_GAP;
                    else if (change_q != 8'd0)
                        pay = 1'b1;
                    else
                        state_d = S_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    tkt_req_d = 1'b1;
                end
            end
            S_TKT_GAP: begin
                state_d   = S_TKT_REQ;
                tkt_req_d = 1'b1;
            end
            S_COIN: begin
                if (change_q == 8'd0)
                    state_d = S_DONE;
                else
                    pay = 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: if (fault_clr) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Greedy payout; the first coin goes out on the edge that enters COIN
        // so it appears the cycle after launch or after the last ack.
        if (pay) begin
            state_d = S_COIN;
            if (change_d >= BIG_V) begin
                coin_big_d = 1'b1;
                change_d   = change_d - BIG_V;
            end else if (change_d >= MID_V) begin
                coin_mid_d = 1'b1;
                change_d   = change_d - MID_V;
            end else begin
                coin_one_d = 1'b1;
                change_d   = change_d - 8'd1;
            end
        end

        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
        busy_d  = (state_d == S_TKT_REQ) || (state_d == S_TKT_GAP) || (state_d == S_COIN);
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            type_q     <= 2'd0;
            rem_q      <= 2'd0;
            cnt_q      <= '0;
            tkt_req_q  <= 1'b0;
            coin_big_q <= 1'b0;
            coin_mid_q <= 1'b0;
            coin_one_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            tickets_q  <= 2'd0;
            change_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            type_q     <= type_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            tkt_req_q  <= tkt_req_d;
            coin_big_q <= coin_big_d;
            coin_mid_q <= coin_mid_d;
            coin_one_q <= coin_one_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            tickets_q  <= tickets_d;
            change_q   <= change_d;
        end
    end

    assign tkt_req     = tkt_req_q;
    assign tkt_type    = type_q;
    assign coin_big    = coin_big_q;
    assign coin_mid    = coin_mid_q;
    assign coin_one    = coin_one_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign tickets_out = tickets_q;
    assign change_left = change_q;

endmodule

// File: tb/tb_ticket_change_dispenser.sv
// Bench for ticket_change_dispenser: table vectors, randomized jobs against a
// count-level model, and hand sequences for start hold and mid-job reset.
module tb_ticket_change_dispenser;

    localparam int BIG = 10;
    localparam int MID = 5;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] ticket_type = 2'd0;
    logic [1:0] ticket_count = 2'd0;
    logic [7:0] change = 8'd0;
    logic       fault_clr = 1'b0;
    logic       tkt_ack = 1'b0;
    logic       tkt_req, coin_big, coin_mid, coin_one, busy, done, fault;
    logic [1:0] tkt_type, tickets_out;
    logic [7:0] change_left;

    int total = 0;
    int bad = 0;
    int p_delay = 0;
    int p_allow = 0;
    int p_age = 0;

    typedef struct {
        int done_n, fault_n, tickets, left, big, mid, one, req, end_cyc;
    } exp_t;

    typedef struct {
        int cnt, chg, typ, delay, allow;
        exp_t e;
    } vec_t;

    ticket_change_dispenser #(.COIN_BIG(BIG), .COIN_MID(MID), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .ticket_type(ticket_type),
        .ticket_count(ticket_count), .change(change), .fault_clr(fault_clr),
        .tkt_req(tkt_req), .tkt_type(tkt_type), .tkt_ack(tkt_ack),
        .coin_big(coin_big), .coin_mid(coin_mid), .coin_one(coin_one),
        .busy(busy), .done(done), .fault(fault),
        .tickets_out(tickets_out), .change_left(change_left)
    );

    always #5 clk = ~clk;

    // Printer: acks after p_delay cycles of req, up to p_allow tickets per job.
    always @(negedge clk) begin
        if (tkt_req && int'(tickets_out) < p_allow) begin
            if (p_age >= p_delay) begin
                tkt_ack = 1'b1;
                p_age = 0;
            end else begin
                tkt_ack = 1'b0;
                p_age = p_age + 1;
            end
        end else begin
            tkt_ack = 1'b0;
            p_age = 0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Reference: counts and cycle positions from the job rules, not from states.
    function automatic exp_t model(input int cnt, input int chg, input int d, input int allow);
        exp_t e;
        int acks;
        acks = (allow < cnt) ? allow : cnt;
        e = '{default: 0};
        if (allow < cnt) begin
            e.fault_n = 1;
            e.tickets = acks;
            e.left    = chg;
            e.req     = acks * (d + 1) + TO;
            e.end_cyc = acks * (d + 1) + acks + TO + 1;
        end else begin
            e.done_n  = 1;
            e.tickets = cnt;
            e.big     = chg / BIG;
            e.mid     = (chg % BIG) / MID;
            e.one     = (chg % BIG) % MID;
            e.req     = cnt * (d + 1);
            e.end_cyc = cnt * (d + 1) + ((cnt > 0) ? cnt - 1 : 0) + e.big + e.mid + e.one + 1;
        end
        return e;
    endfunction

    // Launch one job, watch it to done/fault, compare against e, then recover.
    task automatic run_job(input string nm, input vec_t v);
        exp_t g;
        int last_d, d, order_err, multi_err, type_err;
        g = '{default: 0};
        last_d = 3; order_err = 0; multi_err = 0; type_err = 0;
        p_delay = v.delay;
        p_allow = v.allow;
        @(negedge clk);
        ticket_count = 2'(v.cnt);
        change       = 8'(v.chg);
        ticket_type  = 2'(v.typ);
        start        = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (int'(coin_big) + int'(coin_mid) + int'(coin_one) > 1) multi_err++;
            d = coin_big ? 3 : coin_mid ? 2 : coin_one ? 1 : 0;
            if (d != 0) begin
                if (d > last_d) order_err++;
                last_d = d;
            end
            g.big += int'(coin_big);
            g.mid += int'(coin_mid);
            g.one += int'(coin_one);
            g.req += int'(tkt_req);
            if (busy && int'(tkt_type) != v.typ) type_err++;
            if (done || fault) begin
                g.done_n  = int'(done);
                g.fault_n = int'(fault);
                g.end_cyc = cyc;
                break;
            end
        end
        g.tickets = int'(tickets_out);
        g.left    = int'(change_left);
        chk({nm, " done"}, g.done_n, v.e.done_n);
        chk({nm, " fault"}, g.fault_n, v.e.fault_n);
        chk({nm, " end_cycle"}, g.end_cyc, v.e.end_cyc);
        chk({nm, " tickets_out"}, g.tickets, v.e.tickets);
        chk({nm, " change_left"}, g.left, v.e.left);
        chk({nm, " n_big"}, g.big, v.e.big);
        chk({nm, " n_mid"}, g.mid, v.e.mid);
        chk({nm, " n_one"}, g.one, v.e.one);
        chk({nm, " req_cycles"}, g.req, v.e.req);
        chk({nm, " coin_order"}, order_err, 0);
        chk({nm, " multi_strobe"}, multi_err, 0);
        chk({nm, " tkt_type"}, type_err, 0);
        if (fault) begin
            chk({nm, " req_low_in_fault"}, int'(tkt_req), 0);
            fault_clr = 1'b1;
            @(negedge clk);
            fault_clr = 1'b0;
            chk({nm, " fault_cleared"}, int'(fault), 0);
        end else begin
            @(negedge clk);
            chk({nm, " done_one_cycle"}, int'(done), 0);
        end
        chk({nm, " idle_not_busy"}, int'(busy), 0);
    endtask

    initial begin
        vec_t tbl[6];
        vec_t rv;
        int dn, nb;
        bit seen;

        tbl[0] = '{2, 17,  1, 1, 3, '{1, 0, 2, 0,  1, 1, 2,  4, 10}};
        tbl[1] = '{0, 0,   2, 0, 0, '{1, 0, 0, 0,  0, 0, 0,  0,  1}};
        tbl[2] = '{1, 8,   3, 0, 0, '{0, 1, 0, 8,  0, 0, 0, 16, 17}};
        tbl[3] = '{0, 255, 0, 0, 0, '{1, 0, 0, 0, 25, 1, 0,  0, 27}};
        tbl[4] = '{3, 9,   2, 2, 1, '{0, 1, 1, 9,  0, 0, 0, 19, 21}};
        tbl[5] = '{1, 4,   1, 0, 1, '{1, 0, 1, 0,  0, 0, 4,  1,  6}};

        repeat (3) @(negedge clk);
        chk("reset outputs", int'({tkt_req, tkt_type, coin_big, coin_mid, coin_one,
                                  busy, done, fault, tickets_out, change_left}), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_job($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 25; i++) begin
            rv.cnt   = int'($urandom_range(0, 3));
            rv.chg   = int'($urandom_range(0, 255));
            rv.typ   = int'($urandom_range(0, 3));
            rv.delay = int'($urandom_range(0, 4));
            rv.allow = ($urandom_range(0, 3) == 0 && rv.cnt > 0) ?
                       int'($urandom_range(0, rv.cnt - 1)) : rv.cnt;
            rv.e = model(rv.cnt, rv.chg, rv.delay, rv.allow);
            run_job($sformatf("rnd%0d", i), rv);
        end

        // start held high for 40 cycles launches a single job
        p_delay = 0; p_allow = 1; dn = 0;
        ticket_count = 2'd1; change = 8'd3; start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            dn += int'(done);
        end
        start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            dn += int'(done);
        end
        chk("held start done count", dn, 1);

        // a second start pulse while busy is ignored
        p_delay = 3; p_allow = 2; dn = 0; nb = 0;
        ticket_count = 2'd2; change = 8'd30; start = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            start = (c == 3);
            dn += int'(done);
            nb += int'(coin_big);
        end
        chk("busy restart done count", dn, 1);
        chk("busy restart big coins", nb, 3);

        // reset during COIN after two strobes
        p_allow = 0; nb = 0; seen = 1'b0;
        ticket_count = 2'd0; change = 8'd30; start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            nb += int'(coin_big);
            if (nb == 2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("two strobes before reset", int'(seen), 1);
        rst = 1'b1;
        #1;
        chk("outputs after async reset", int'({tkt_req, tkt_type, coin_big, coin_mid, coin_one,
                                             busy, done, fault, tickets_out, change_left}), 0);
        @(negedge clk);
        rst = 1'b0;
        rv = '{1, 12, 2, 1, 1, '{1, 0, 1, 0, 1, 0, 2, 2, 6}};
        run_job("post reset", rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
